// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the matrix request path,
// plus the state type of the per-master request port.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AWAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } req_state_e;

endpackage

// File: rtl/ahb_onehot_lsb.sv
// Keeps only the lowest set bit of a vector, so a
// malformed multi-hot decode still yields one slave.
module ahb_onehot_lsb #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] vec_i,
   output logic [W-1:0] lsb_o
);

   assign lsb_o = vec_i & (~vec_i + W'(1));

endmodule

// File: rtl/ahb_mst_req_port.sv
// Per-master request stage: buffers the address phase,
// requests the decoded slave arbiter, tracks the data phase.
module ahb_mst_req_port
   import ahb_pkg::*;
#(
   parameter int unsigned SLAVES     = 4,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  S_HSEL,
   input  logic [1:0]            S_HTRANS,
   input  logic [ADDR_WIDTH-1:0] S_HADDR,
   input  logic                  S_HWRITE,
   input  logic [2:0]            S_HSIZE,
   input  logic [2:0]            S_HBURST,
   input  logic [3:0]            S_HPROT,
   input  logic                  S_HMASTLOCK,
   input  logic                  S_HREADY,
   output logic                  S_HREADYOUT,
   output logic                  S_HRESP,
   input  logic [SLAVES-1:0]     DEC_SLV_SEL,
   output logic [SLAVES-1:0]     ARB_REQ,
   input  logic [SLAVES-1:0]     ARB_REQ_ACK,
   output logic                  ARB_LOCK,
   output logic [1:0]            M_HTRANS,
   output logic [ADDR_WIDTH-1:0] M_HADDR,
   output logic                  M_HWRITE,
   output logic [2:0]            M_HSIZE,
   output logic [2:0]            M_HBURST,
   output logic [3:0]            M_HPROT,
   output logic                  M_HMASTLOCK,
   output logic [SLAVES-1:0]     DP_SLV_SEL,
   input  logic                  M_HREADY,
   input  logic                  M_HRESP
);

   req_state_e state_q, state_d;

   logic [SLAVES-1:0]     dec_lsb;
   logic [SLAVES-1:0]     sel_q;
   logic [SLAVES-1:0]     dp_q, dp_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [2:0]            size_q;
   logic [3:0]            prot_q;
   logic                  lock_q;

   logic accept;
   logic hit;
   logic ack_hit;
   logic load;
   logic unused_bits;

   ahb_onehot_lsb #(
      .W (SLAVES)
   ) u_dec_lsb (
      .vec_i (DEC_SLV_SEL),
      .lsb_o (dec_lsb)
   );

   assign accept  = S_HSEL & S_HREADY & S_HTRANS[1];
   assign hit     = |dec_lsb;
   assign ack_hit = |(ARB_REQ_ACK & sel_q);

   // Every beat is re-arbitrated, so the master's type/burst are not kept
   assign unused_bits = ^{S_HTRANS[0], S_HBURST};

   always_comb begin
      state_d = state_q;
      dp_d    = '0;
      load    = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (accept) begin
               load    = 1'b1;
               state_d = hit ? ST_AWAIT : ST_ERR1;
            end
         end
         ST_AWAIT: begin
            if (ack_hit) begin
               state_d = ST_DATA;
               dp_d    = sel_q;
            end
         end
         ST_DATA: begin
            if (M_HREADY) begin
               state_d = ST_IDLE;
               if (accept) begin
                  load    = 1'b1;
                  state_d = hit ? ST_AWAIT : ST_ERR1;
               end
            end else begin
               dp_d = dp_q;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         dp_q    <= '0;
      end else begin
         state_q <= state_d;
         dp_q    <= dp_d;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         prot_q  <= '0;
         lock_q  <= 1'b0;
      end else if (load) begin
         sel_q   <= dec_lsb;
         addr_q  <= S_HADDR;
         write_q <= S_HWRITE;
         size_q  <= S_HSIZE;
         prot_q  <= S_HPROT;
         lock_q  <= S_HMASTLOCK;
      end
   end

   always_comb begin
      S_HREADYOUT = 1'b1;
      S_HRESP     = HRESP_OKAY;
      ARB_REQ     = '0;
      ARB_LOCK    = 1'b0;
      M_HTRANS    = HTRANS_IDLE;
      unique case (state_q)
         ST_AWAIT: begin
            S_HREADYOUT = 1'b0;
            ARB_REQ     = sel_q;
            ARB_LOCK    = lock_q;
            M_HTRANS    = HTRANS_NONSEQ;
         end
         ST_DATA: begin
            S_HREADYOUT = M_HREADY;
            S_HRESP     = M_HRESP;
            ARB_LOCK    = lock_q;
         end
         ST_ERR1: begin
            S_HREADYOUT = 1'b0;
            S_HRESP     = HRESP_ERROR;
         end
         ST_ERR2: begin
            S_HREADYOUT = 1'b1;
            S_HRESP     = HRESP_ERROR;
         end
         default: begin
            S_HREADYOUT = 1'b1;
         end
      endcase
   end

   assign M_HADDR     = addr_q;
   assign M_HWRITE    = write_q;
   assign M_HSIZE     = size_q;
   assign M_HBURST    = HBURST_SINGLE;
   assign M_HPROT     = prot_q;
   assign M_HMASTLOCK = lock_q;
   assign DP_SLV_SEL  = dp_q;

endmodule
